// File: rtl/bch_pkg.sv
// bch_pkg: shared constants and constant functions for the BCH blocks.
//   calc_m            field degree M from codeword length N
//   prim_low          primitive polynomial per M, without the x^M term
//   gf_mul_alpha      multiply a field element by alpha
//   gf_alpha_pow      alpha^e in polynomial basis
//   const_mul_matrix  GF(2) matrix for constant multiply by alpha^e
//                     (column c is the image of basis element x^c)
//   bch_legal         (N, K, T) legality check
//   calc_w / calc_p   words per frame and leading pad bits
package bch_pkg;

  localparam int MAX_M = 16;

  typedef logic [MAX_M-1:0]            gf_t;
  typedef logic [MAX_M-1:0][MAX_M-1:0] mat_t;

  function automatic int calc_m(input int n);
    return $clog2(n + 1);
  endfunction

  // M = 4 is x^4 + x + 1.
  function automatic gf_t prim_low(input int m);
    case (m)
      3:       return gf_t'('h3);    // x^3 + x + 1
      4:       return gf_t'('h3);    // x^4 + x + 1
      5:       return gf_t'('h5);    // x^5 + x^2 + 1
      6:       return gf_t'('h3);    // x^6 + x + 1
      7:       return gf_t'('h9);    // x^7 + x^3 + 1
      8:       return gf_t'('h1d);   // x^8 + x^4 + x^3 + x^2 + 1
      9:       return gf_t'('h11);   // x^9 + x^4 + 1
      10:      return gf_t'('h9);    // x^10 + x^3 + 1
      default: return '0;
    endcase
  endfunction

  function automatic gf_t gf_mul_alpha(input gf_t a, input int m);
    gf_t msk;
    gf_t r;
    msk = gf_t'((32'd1 << m) - 1);
    r   = (a << 1) & msk;
    if (a[m-1]) r = r ^ prim_low(m);
    return r;
  endfunction

  function automatic gf_t gf_alpha_pow(input int e, input int m);
    int  n;
    gf_t r;
    n = (1 << m) - 1;
    r = gf_t'(1);
    for (int i = 0; i < (e % n); i++) r = gf_mul_alpha(r, m);
    return r;
  endfunction

  function automatic mat_t const_mul_matrix(input int e, input int m);
    mat_t r;
    gf_t  col;
    r   = '0;
    col = gf_alpha_pow(e, m);
    for (int c = 0; c < m; c++) begin
      r[c] = col;
      col  = gf_mul_alpha(col, m);
    end
    return r;
  endfunction

  function automatic bit bch_legal(input int n, input int k, input int t);
    int m;
    m = calc_m(n);
    return (n == (1 << m) - 1) && (m >= 3) && (m <= 10) &&
           (t >= 1) && (2 * t < n) && (k >= 1) && (k < n) &&
           ((n - k) <= m * t);
  endfunction

  function automatic int calc_w(input int n, input int bits);
    return (n + bits - 1) / bits;
  endfunction

  function automatic int calc_p(input int n, input int bits);
    return calc_w(n, bits) * bits - n;
  endfunction

endpackage

// File: rtl/bch_syn_lane.sv
// bch_syn_lane: one odd-syndrome accumulator S_J with its constant XOR trees.
//   clk, reset  clock, async active-high reset
//   en          word accepted this cycle
//   first       accepted word is word 0 of a frame (load, do not accumulate)
//   data        masked input word, bit BITS-1 earliest
//   nxt         data-included next accumulator value (combinational)
module bch_syn_lane
  import bch_pkg::*;
#(
  parameter int M    = 4,
  parameter int J    = 1,
  parameter int BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            first,
  input  logic [BITS-1:0] data,
  output logic [M-1:0]    nxt
);

  // Feedback matrix: multiply by alpha^(J*BITS).
  function automatic logic [M-1:0][M-1:0] build_fb();
    mat_t                   full;
    logic [M-1:0][M-1:0]    r;
    full = const_mul_matrix(J * BITS, M);
    for (int c = 0; c < M; c++) r[c] = full[c][M-1:0];
    return r;
  endfunction

  // Data term: bit b contributes alpha^(J*b).
  function automatic logic [BITS-1:0][M-1:0] build_dt();
    gf_t                    v;
    logic [BITS-1:0][M-1:0] r;
    for (int b = 0; b < BITS; b++) begin
      v    = gf_alpha_pow(J * b, M);
      r[b] = v[M-1:0];
    end
    return r;
  endfunction

  localparam logic [M-1:0][M-1:0]    FB = build_fb();
  localparam logic [BITS-1:0][M-1:0] DT = build_dt();

  logic [M-1:0] acc;
  logic [M-1:0] fb_term;
  logic [M-1:0] dt_term;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fb_term = '0;
    dt_term = '0;
    for (int c = 0; c < M; c++)
      if (acc[c]) fb_term = fb_term ^ FB[c];
    for (int b = 0; b < BITS; b++)
      if (data[b]) dt_term = dt_term ^ DT[b];
    nxt = first ? dt_term : (fb_term ^ dt_term);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset)   acc <= '0;
    else if (en) acc <= nxt;
  end

endmodule

// File: rtl/bch_syndrome_par.sv
// bch_syndrome_par: parallel-input BCH odd-syndrome generator.
//   clk, reset   clock, async active-high reset
//   in_valid     in_data holds a valid word
//   in_ready     word accepted this cycle (stalls only on a frame's last word)
//   in_data      BITS received bits, bit BITS-1 earliest / highest degree
//   syn_valid    registered frame result available
//   syn_ready    downstream takes the result
//   syndromes    S(2i-1) in bits [i*M-1:(i-1)*M], i = 1..T
//   syn_error    OR of all syndrome bits
module bch_syndrome_par
  import bch_pkg::*;
#(
  parameter int N    = 15,
  parameter int K    = 5,
  parameter int T    = 3,
  parameter int BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITS-1:0]          in_data,
  output logic                     syn_valid,
  input  logic                     syn_ready,
  output logic [T*calc_m(N)-1:0]   syndromes,
  output logic                     syn_error
);

  localparam int M  = calc_m(N);
  localparam int W  = calc_w(N, BITS);
  localparam int P  = calc_p(N, BITS);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0]   LAST_CNT = CW'(W - 1);
  // Clears the P leading pad bits of word 0.
  localparam logic [BITS-1:0] KEEP     = {BITS{1'b1}} >> P;

  if (!bch_legal(N, K, T) || (BITS < 1) || (BITS > N)) begin : g_bad_params
    $error("bch_syndrome_par: illegal N/K/T/BITS combination");
  end

  logic [CW-1:0]   word_cnt;
  logic            first;
  logic            last;
  logic            accept;
  logic [BITS-1:0] data;
  logic [T*M-1:0]  nxt;

  assign first    = (word_cnt == '0);
  assign last     = (word_cnt == LAST_CNT);
  // The final word can only go in when the output register is free or draining.
  assign in_ready = !last || !syn_valid || syn_ready;
  assign accept   = in_valid && in_ready;
  assign data     = first ? (in_data & KEEP) : in_data;

  for (genvar i = 0; i < T; i++) begin : g_lane
    bch_syn_lane #(
      .M    (M),
      .J    (2 * i + 1),
      .BITS (BITS)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .first (first),
      .data  (data),
      .nxt   (nxt[i*M +: M])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      syn_valid <= 1'b0;
      syndromes <= '0;
      syn_error <= 1'b0;
    end else begin
      if (accept) word_cnt <= last ? '0 : word_cnt + 1'b1;
      // A completing frame wins over a drain in the same cycle.
      if (accept && last) begin
        syn_valid <= 1'b1;
        syndromes <= nxt;
        syn_error <= |nxt;
      end else if (syn_ready) begin
        syn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_syndrome_par.sv
module tb_bch_syndrome_par;

  localparam int NI = 4;

  function automatic int bits_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NI];
  logic [14:0] in_data   [NI];
  logic        syn_ready [NI];
  logic        in_ready  [NI];
  logic        syn_valid [NI];
  logic [11:0] syndromes [NI];
  logic        syn_error [NI];

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_syn_q [$];
  logic        exp_err_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BV = bits_of(g);
    bch_syndrome_par #(.N(15), .K(5), .T(3), .BITS(BV)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g][BV-1:0]),
      .syn_valid (syn_valid[g]),
      .syn_ready (syn_ready[g]),
      .syndromes (syndromes[g]),
      .syn_error (syn_error[g])
    );
  end

  // Reference: S_j = sum over set bits c_i of alpha^(i*j), GF(16), x^4+x+1.
  function automatic logic [11:0] model_syn(input logic [14:0] cw);
    logic [3:0]  pw [15];
    logic [4:0]  x;
    logic [3:0]  s;
    logic [11:0] r;
    x = 5'd1;
    for (int e = 0; e < 15; e++) begin
      pw[e] = x[3:0];
      x = x << 1;
      if (x[4]) x = x ^ 5'h13;
    end
    r = '0;
    for (int jj = 0; jj < 3; jj++) begin
      s = '0;
      for (int i = 0; i < 15; i++)
        if (cw[i]) s = s ^ pw[(i * (2 * jj + 1)) % 15];
      r[jj*4 +: 4] = s;
    end
    return r;
  endfunction

  // Valid BCH(15,5) codeword: msg(x) * g(x), g = x^10+x^8+x^5+x^4+x^2+x+1.
  function automatic logic [14:0] make_cw(input logic [4:0] msg);
    logic [14:0] cw;
    cw = '0;
    for (int i = 0; i < 5; i++)
      if (msg[i]) cw = cw ^ (15'h537 << i);
    return cw;
  endfunction

  // Word idx of a frame: the pad bits sit above c(14) in the first word.
  function automatic logic [14:0] word_of(input int k, input logic [14:0] cw,
                                          input logic [15:0] pad, input int idx);
    int          b, w, p;
    logic [31:0] padded;
    b = bits_of(k);
    w = (15 + b - 1) / b;
    p = w * b - 15;
    padded = {17'd0, cw} | (({16'd0, pad} & ((32'd1 << p) - 1)) << 15);
    return 15'((padded >> ((w - 1 - idx) * b)) & ((32'd1 << b) - 1));
  endfunction

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 15'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic send_word(input int k, input logic [14:0] d);
    logic rdy;
    bit   done;
    done = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      rdy = in_ready[k];
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    in_valid[k] = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_word_timeout inst=%0d got=no_accept want=accept", k);
    end
  endtask

  task automatic send_frame(input int k, input logic [14:0] cw,
                            input logic [15:0] pad, input int gap_max);
    int w;
    w = (15 + bits_of(k) - 1) / bits_of(k);
    for (int i = 0; i < w; i++) begin
      idle(k, $urandom_range(0, gap_max));
      send_word(k, word_of(k, cw, pad, i));
    end
  endtask

  // Pops n results, comparing against the expected queues.
  task automatic collect(input int k, input int n, input bit rand_ready, input int budget);
    int          got;
    logic [11:0] es;
    logic        ee;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      syn_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (syn_valid[k] && syn_ready[k]) begin
        checks++;
        if (exp_syn_q.size() == 0) begin
          failures++;
          $display("FAIL collect_unexpected inst=%0d got=%h want=none", k, syndromes[k]);
        end else begin
          es = exp_syn_q.pop_front();
          ee = exp_err_q.pop_front();
          if (syndromes[k] !== es) begin
            failures++;
            $display("FAIL collect_syn inst=%0d got=%h want=%h", k, syndromes[k], es);
          end
          checks++;
          if (syn_error[k] !== ee) begin
            failures++;
            $display("FAIL collect_err inst=%0d got=%b want=%b", k, syn_error[k], ee);
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    syn_ready[k] = 1'b1;
    if (got < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout inst=%0d got=%0d want=%0d", k, got, n);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (syn_valid[k] !== 1'b0 || syndromes[k] !== 12'h000 ||
          syn_error[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=v%b s%h e%b r%b want=v0 s000 e0 r1",
                 k, syn_valid[k], syndromes[k], syn_error[k], in_ready[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int          pulses;
    int          pulse_at;
    logic [11:0] pulse_syn;
    logic        pulse_err;
    // Leave a held result and a partial frame behind.
    syn_ready[0] = 1'b0;
    send_frame(0, 15'h0008, 16'h0, 0);
    for (int i = 0; i < 7; i++) send_word(0, 15'h1);
    rst = 1'b1;
    #1;
    checks++;
    if (syn_valid[0] !== 1'b0 || syndromes[0] !== 12'h000 || syn_error[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear got=v%b s%h e%b want=v0 s000 e0",
               syn_valid[0], syndromes[0], syn_error[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    syn_ready[0] = 1'b1;
    pulses = 0; pulse_at = -1; pulse_syn = '1; pulse_err = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      if (i <= 15) send_word(0, 15'h0);
      else idle(0, 1);
      if (syn_valid[0]) begin
        pulses++; pulse_at = i; pulse_syn = syndromes[0]; pulse_err = syn_error[0];
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 15) begin
      failures++;
      $display("FAIL reset_mid_pulses got=%0d@%0d want=1@15", pulses, pulse_at);
    end
    checks++;
    if (pulse_syn !== 12'h000 || pulse_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_value got=s%h e%b want=s000 e0", pulse_syn, pulse_err);
    end
  endtask

  task automatic test_single_c0();
    syn_ready[0] = 1'b1;
    for (int i = 0; i < 14; i++) send_word(0, 15'h0);
    checks++;
    if (syn_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL c0_early_valid got=%b want=0", syn_valid[0]);
    end
    send_word(0, 15'h1);
    checks++;
    if (syn_valid[0] !== 1'b1 || syndromes[0] !== 12'h111 || syn_error[0] !== 1'b1) begin
      failures++;
      $display("FAIL c0_result got=v%b s%h e%b want=v1 s111 e1",
               syn_valid[0], syndromes[0], syn_error[0]);
    end
    idle(0, 2);
  endtask

  task automatic test_mask();
    syn_ready[2] = 1'b1;
    send_word(2, 15'b1000);   // pad bit set, must be ignored
    send_word(2, 15'b0000);
    send_word(2, 15'b0000);
    send_word(2, 15'b0010);
    checks++;
    if (syn_valid[2] !== 1'b1 || syndromes[2] !== 12'h682 || syn_error[2] !== 1'b1) begin
      failures++;
      $display("FAIL mask_c1 got=v%b s%h e%b want=v1 s682 e1",
               syn_valid[2], syndromes[2], syn_error[2]);
    end
    idle(2, 2);
  endtask

  task automatic test_back_to_back();
    logic [14:0] cws  [3];
    logic [15:0] pads [3];
    bit          exp_v;
    for (int f = 0; f < 3; f++) begin
      cws[f]  = 15'($urandom);
      pads[f] = 16'($urandom);
    end
    syn_ready[2] = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (t < 12) begin
        in_valid[2] = 1'b1;
        in_data[2]  = word_of(2, cws[t/4], pads[t/4], t % 4);
      end else begin
        in_valid[2] = 1'b0;
      end
      @(negedge clk);
      if (t < 12) begin
        checks++;
        if (in_ready[2] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready t=%0d got=%b want=1", t, in_ready[2]);
        end
      end
      exp_v = (t == 4) || (t == 8) || (t == 12);
      checks++;
      if (syn_valid[2] !== exp_v) begin
        failures++;
        $display("FAIL b2b_valid t=%0d got=%b want=%b", t, syn_valid[2], exp_v);
      end
      if (exp_v) begin
        checks++;
        if (syndromes[2] !== model_syn(cws[t/4-1])) begin
          failures++;
          $display("FAIL b2b_syn t=%0d got=%h want=%h", t, syndromes[2], model_syn(cws[t/4-1]));
        end
      end
      @(posedge clk); #1;
    end
    idle(2, 1);
  endtask

  task automatic test_backpressure();
    logic [14:0] ca, cb;
    logic [11:0] sa, sb;
    ca = 15'($urandom); cb = 15'($urandom);
    sa = model_syn(ca); sb = model_syn(cb);
    syn_ready[2] = 1'b0;
    send_frame(2, ca, 16'hffff, 0);
    checks++;
    if (syn_valid[2] !== 1'b1 || syndromes[2] !== sa) begin
      failures++;
      $display("FAIL bp_first got=v%b s%h want=v1 s%h", syn_valid[2], syndromes[2], sa);
    end
    for (int i = 0; i < 3; i++) send_word(2, word_of(2, cb, 16'h0, i));
    in_valid[2] = 1'b1;
    in_data[2]  = word_of(2, cb, 16'h0, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready[2] !== 1'b0 || syn_valid[2] !== 1'b1 || syndromes[2] !== sa) begin
        failures++;
        $display("FAIL bp_hold c=%0d got=r%b v%b s%h want=r0 v1 s%h",
                 c, in_ready[2], syn_valid[2], syndromes[2], sa);
      end
      @(posedge clk); #1;
    end
    syn_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready[2] !== 1'b1 || syndromes[2] !== sa) begin
      failures++;
      $display("FAIL bp_release got=r%b s%h want=r1 s%h", in_ready[2], syndromes[2], sa);
    end
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (syn_valid[2] !== 1'b1 || syndromes[2] !== sb) begin
      failures++;
      $display("FAIL bp_second got=v%b s%h want=v1 s%h", syn_valid[2], syndromes[2], sb);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (syn_valid[2] !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b want=0", syn_valid[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    localparam int NF = 6;
    logic [14:0] cws  [NF];
    logic [15:0] pads [NF];
    int          nerr, pos;
    logic [14:0] emask;
    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < NF; f++) begin
        nerr  = f % 4;
        emask = '0;
        while ($countones(emask) < nerr) begin
          pos = $urandom_range(0, 14);
          emask[pos] = 1'b1;
        end
        cws[f]  = make_cw(5'($urandom)) ^ emask;
        pads[f] = 16'($urandom);
        exp_syn_q.push_back(model_syn(cws[f]));
        exp_err_q.push_back(nerr != 0);
      end
      fork
        for (int f = 0; f < NF; f++) send_frame(k, cws[f], pads[f], 2);
        collect(k, NF, 1'b1, 4000);
      join
      checks++;
      if (syn_valid[k] !== 1'b0) begin
        failures++;
        $display("FAIL rand_extra inst=%0d got=%b want=0", k, syn_valid[k]);
      end
      exp_syn_q.delete();
      exp_err_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      syn_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid_frame();
    test_single_c0();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_par.md
# bch_syndrome_par

Parallel-input BCH syndrome generator: the first stage of the next-generation multi-bit-per-cycle decoder. It consumes a received N-bit codeword BITS bits per cycle over a valid/ready stream and computes the T odd syndromes S1, S3, …, S(2T-1) over GF(2^M). It presents them, with an error flag, on a registered valid/ready output. Even syndromes are not produced; downstream error-locator logic derives them by squaring.

## Interface
- N, 15: codeword length; N = 2^M − 1, M = log2(N+1).
- K, 5: message length. Used only for the package legality check on (N, K, T).
- T, 3: correctable errors; number of syndromes produced.
- BITS, 1: received bits per input word; 1 ≤ BITS ≤ N.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  BITS  received bits; bit BITS-1 is earliest in time (highest codeword degree).
- syn_valid  out  1  syndromes and syn_error hold a complete frame result.
- syn_ready  in  1  downstream accepts the result this cycle.
- syndromes  out  T*M  S(2i−1) in bits [i*M−1:(i−1)*M], i = 1..T; polynomial basis.
- syn_error  out  1  OR of all syndrome bits; any error detected.

## Operation
- A frame is W = ceil(N/BITS) accepted words. The first word's P = W*BITS − N leading bits (in_data[BITS-1:BITS-P]) are padding and are masked to zero.
- Codeword order: the first received bit is c(N−1) and the last is c(0). S_j = Σ c_i·α^(i·j).
- Horner per syndrome on each accepted word: acc_j ← acc_j·α^(j·BITS) ⊕ Σ_b d_b·α^(j·b), where d_b = in_data[b] after masking. Both terms are constant GF(2) matrices and reduce to XOR trees; no multipliers.
- word_cnt counts 0..W−1. On the first word, acc_j is loaded with the data term only, so there is no clear cycle between frames.
- On acceptance of word W−1:
  - the data-included next value of acc is written to the output register;
  - syn_valid is set;
  - word_cnt wraps to 0.
- Output register holds its value while syn_valid && !syn_ready. syn_valid clears on syn_valid && syn_ready unless a new frame completes in the same cycle, in which case the register reloads and syn_valid stays 1.
- in_ready = (word_cnt != W−1) || !syn_valid || syn_ready. Only the final word of a frame can stall.
- With W = 1 (BITS ≥ N), every accepted word is a full frame.

## Timing
- Reset values: syn_valid 0, syndromes 0, syn_error 0, word_cnt 0, accumulators 0. in_ready is 1 after reset.
- Reset mid-frame discards the partial frame and any held result. The next accepted word is treated as word 0.
- Latency: syn_valid rises the cycle after the final word is accepted; results are registered, with no combinational path from in_data.
- Throughput: one word per cycle sustained when syn_ready = 1. Frames run back-to-back with no bubble.
- Backpressure: result held stable while syn_ready = 0, and the next frame's words 0..W−2 are still absorbed. in_data and in_valid changes while in_ready = 0 have no effect.
- in_valid = 0 cycles anywhere in a frame are legal and freeze state.

## Structure
- Shared package bch_pkg (extends bch.vh) holds:
  - M derivation;
  - the primitive polynomial per M (M = 4: x^4+x+1);
  - the (N, K, T) legality check;
  - a function returning the M×M GF(2) matrix for constant multiply by α^e;
  - W and P constants.
- One sub-module, bch_syn_lane (#(M, J, BITS)): one syndrome's accumulator plus its constant XOR trees. bch_syndrome_par instantiates T lanes with J = 1, 3, …, 2T−1 and owns the counter, masking and handshake.

## Test plan
- Reset mid-frame:
  - Stimulus: N=15, T=3, BITS=1, assert reset after 7 bits, then stream an all-zero frame.
  - Required: exactly one result, syndromes = 12'h000, syn_error = 0.
- Single error at c(0), BITS=1:
  - Stimulus: 14 zeros then one 1.
  - Required: syndromes = 12'h111, syn_error = 1, syn_valid the cycle after bit 15.
- Single error at c(1), BITS=4 (W=4, P=1, pad bit = 1 to check masking):
  - Stimulus: last word 4'b0010.
  - Required: S1 = 2, S3 = 8, S5 = 6, i.e. syndromes = 12'h682.
- Back-to-back frames, BITS=4, syn_ready = 1:
  - Stimulus: three frames with no gaps.
  - Required: in_ready constantly 1, three syn_valid pulses 4 cycles apart, each matching a software model.
- Backpressure:
  - Stimulus: hold syn_ready = 0 across two frames.
  - Required: first result held unchanged, in_ready = 0 only on frame 2's last word. Both results delivered in order after syn_ready rises.
- Random regression:
  - Stimulus: random codewords with 0..T injected errors, random in_valid and syn_ready, BITS ∈ {1, 3, 4, 15}.
  - Required: syndromes match the reference model; syn_error = 0 exactly for error-free frames.
